// File: rtl/sram_burst.sv
// Small register-file SRAM with an address register, single-word read/write
// and an auto-incrementing read burst engine.
module sram_burst #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          okay,
  input  logic          ldar,
  input  logic          rw,
  input  logic          inc,
  input  logic [AW-1:0] address,
  input  logic [AW:0]   blen,
  input  logic [DW-1:0] datain,
  output logic [DW-1:0] dataout,
  output logic          dvalid,
  output logic          busy,
  output logic          err,
  output logic [AW-1:0] addr_q
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LEN = (AW+1)'(1'b1);
  localparam logic [AW-1:0] ONE_ADDR = AW'(1'b1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state_q;
  logic [AW:0]   blen_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   eff_len_d;
  logic [DW-1:0] mem_q [DEPTH];

  // Effective burst length: zero means one word, oversize clamps to full depth.
  always_comb begin
    eff_len_d = blen_q;
    if (blen_q == {(AW+1){1'b0}}) begin
      eff_len_d = ONE_LEN;
    end else if (blen_q > MAX_LEN) begin
      eff_len_d = MAX_LEN;
    end else begin
      eff_len_d = blen_q;
    end
  end

  // Command FSM, memory array and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= {AW{1'b0}};
      blen_q  <= {(AW+1){1'b0}};
      cnt_q   <= {(AW+1){1'b0}};
      dataout <= {DW{1'b0}};
      dvalid  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else begin
      dvalid <= 1'b0;
      err    <= 1'b0;
      case (state_q)
        IDLE: begin
          busy <= 1'b0;
          if (okay) begin
            if (ldar) begin
              addr_q <= address;
              blen_q <= blen;
            end else if (!rw) begin
              mem_q[addr_q] <= datain;
              addr_q        <= addr_q + AW'(inc);
            end else begin
              dataout <= mem_q[addr_q];
              dvalid  <= 1'b1;
              if (eff_len_d == ONE_LEN) begin
                addr_q <= addr_q + AW'(inc);
              end else begin
                // Word 0 leaves now; the remaining L-1 words stream from BURST.
                addr_q  <= addr_q + ONE_ADDR;
                cnt_q   <= eff_len_d - ONE_LEN;
                state_q <= BURST;
                busy    <= 1'b1;
              end
            end
          end
        end
        BURST: begin
          dataout <= mem_q[addr_q];
          dvalid  <= 1'b1;
          addr_q  <= addr_q + ONE_ADDR;
          cnt_q   <= cnt_q - ONE_LEN;
          err     <= okay;
          if (cnt_q == ONE_LEN) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_q <= BURST;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst.sv
// Randomized bench for sram_burst against a transaction-level reference model.
module tb_sram_burst;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 2 ** AW;

  logic          clk, rst, okay, ldar, rw, inc;
  logic [AW-1:0] address;
  logic [AW:0]   blen;
  logic [DW-1:0] datain, dataout;
  logic          dvalid, busy, err;
  logic [AW-1:0] addr_q;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic [DW-1:0] m_mem [DEPTH];
  logic [AW-1:0] m_addr;
  logic [AW:0]   m_blen;
  int            busy_left;
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_dout;
  logic          m_dv, m_err;
  logic [DW-1:0] obs [$];

  sram_burst #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .okay(okay), .ldar(ldar), .rw(rw), .inc(inc),
    .address(address), .blen(blen), .datain(datain), .dataout(dataout),
    .dvalid(dvalid), .busy(busy), .err(err), .addr_q(addr_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_addr = '0; m_blen = '0; busy_left = 0;
    m_q.delete(); m_dout = '0; m_dv = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void model_edge();
    bit was_busy;
    int len;
    was_busy = (busy_left > 0);
    m_err = okay && was_busy;
    if (was_busy) busy_left--;
    if (okay && !was_busy) begin
      if (ldar) begin
        m_addr = address;
        m_blen = blen;
      end else if (!rw) begin
        m_mem[m_addr] = datain;
        m_addr = AW'((int'(m_addr) + int'(inc)) % DEPTH);
      end else begin
        len = (m_blen == 0) ? 1 : ((int'(m_blen) > DEPTH) ? DEPTH : int'(m_blen));
        for (int k = 0; k < len; k++) m_q.push_back(m_mem[(int'(m_addr) + k) % DEPTH]);
        if (len == 1) m_addr = AW'((int'(m_addr) + int'(inc)) % DEPTH);
        else m_addr = AW'((int'(m_addr) + len) % DEPTH);
        busy_left = len - 1;
      end
    end
    m_dv = (m_q.size() > 0);
    if (m_dv) m_dout = m_q.pop_front();
  endfunction

  task automatic compare_outputs();
    logic [AW-1:0] exp_addr;
    exp_addr = AW'((int'(m_addr) - busy_left + DEPTH) % DEPTH);
    chk("dvalid", 32'(dvalid), 32'(m_dv));
    chk("busy", 32'(busy), 32'(busy_left > 0));
    chk("err", 32'(err), 32'(m_err));
    chk("dataout", 32'(dataout), 32'(m_dout));
    chk("addr_q", 32'(addr_q), 32'(exp_addr));
  endtask

  task automatic step(input logic ok, input logic ld, input logic r, input logic in_c,
                      input logic [AW-1:0] a, input logic [AW:0] bl, input logic [DW-1:0] d);
    okay = ok; ldar = ld; rw = r; inc = in_c; address = a; blen = bl; datain = d;
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
    if (dvalid) obs.push_back(dataout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_dvalid", 32'(dvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dataout", 32'(dataout), 32'd0);
    chk("rst_addr", 32'(addr_q), 32'd0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; okay = 1'b0; ldar = 1'b0; rw = 1'b0; inc = 1'b0;
    address = '0; blen = '0; datain = '0;
    #2;
    do_reset();

    // single write then read at address 2
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 8'hA5);
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00);
    chk("r034_data", 32'(dataout), 32'h0A5);
    chk("r034_dv", 32'(dvalid), 32'd1);
    chk("r034_addr", 32'(addr_q), 32'd2);
    idle(1);

    // fill memory, wrapping burst from address 3, dropped write mid-burst
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 8'h11);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 8'h22);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 8'h33);
    step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 8'h44);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 3'd4, 8'h00);
    obs.delete();
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 8'hFF);
    chk("r036_err", 32'(err), 32'd1);
    idle(3);
    chk("r035_count", 32'(obs.size()), 32'd4);
    if (obs.size() == 4) begin
      chk("r035_w0", 32'(obs[0]), 32'h44);
      chk("r035_w1", 32'(obs[1]), 32'h11);
      chk("r035_w2", 32'(obs[2]), 32'h22);
      chk("r035_w3", 32'(obs[3]), 32'h33);
    end
    chk("r035_addr", 32'(addr_q), 32'd3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd4, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00);
    idle(4);

    // length boundaries: zero length and oversize clamp
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd0, 8'h00);
    obs.delete();
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00);
    idle(2);
    chk("r037_len0", 32'(obs.size()), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd7, 8'h00);
    obs.delete();
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00);
    idle(5);
    chk("r037_len7", 32'(obs.size()), 32'd4);
    chk("r037_idle", 32'(busy), 32'd0);

    // reset on the second burst cycle, then memory reads back zero
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd4, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00);
    idle(1);
    do_reset();
    idle(2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd4, 8'h00);
    obs.delete();
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 8'h00);
    idle(4);
    chk("r038_count", 32'(obs.size()), 32'd4);
    foreach (obs[i]) chk("r038_zero", 32'(obs[i]), 32'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
             (AW+1)'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_burst.md
SRAM_BURST -- requirements
Module: sram_burst

Interface
REQ-001 SHALL have parameter DW, default 8, data word width in bits.
REQ-002 SHALL have parameter AW, default 2, address width in bits; memory depth is 2**AW words.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port okay  input  1  command strobe, sampled on every rising clk edge (level, not edge-detected).
REQ-006 SHALL have port ldar  input  1  when high with okay: load the address register and the burst length register.
REQ-007 SHALL have port rw  input  1  command type: 1 = read, 0 = write.
REQ-008 SHALL have port inc  input  1  when high, single read/write post-increments the address register.
REQ-009 SHALL have port address  input  AW  address loaded on an LDAR command.
REQ-010 SHALL have port blen  input  AW+1  burst length loaded on an LDAR command.
REQ-011 SHALL have port datain  input  DW  write data.
REQ-012 SHALL have port dataout  output  DW  registered read data.
REQ-013 SHALL have port dvalid  output  1  one-cycle pulse per read word delivered on dataout.
REQ-014 SHALL have port busy  output  1  high while a read burst is in progress.
REQ-015 SHALL have port err  output  1  one-cycle pulse when a command is dropped.
REQ-016 SHALL have port addr_q  output  AW  current address register value.

Function
REQ-017 SHALL accept a command on a rising edge where okay=1 and busy=0.
REQ-018 Command decode SHALL use fixed priority: ldar=1 first, then rw=0 (write), then rw=1 (read).
REQ-019 LDAR SHALL set addr_q <= address and blen register <= blen, and SHALL NOT access memory; an LDAR edge SHALL leave dvalid=0.
REQ-020 A stored blen of 0 SHALL be treated as length 1; values above 2**AW SHALL be clamped to 2**AW.
REQ-021 Write SHALL store datain at mem[addr_q] on the accepting edge; addr_q SHALL increment only if inc=1; dvalid SHALL stay 0.
REQ-022 Read with effective length L=1 SHALL drive dataout <= mem[addr_q] and dvalid=1 for the one cycle after the accepting edge (latency 1); addr_q SHALL increment only if inc=1.
REQ-023 Read with L>1 SHALL always increment addr_q, independent of inc.
REQ-024 The FSM SHALL have two states, IDLE and BURST; reset state is IDLE; busy=1 exactly in BURST.
REQ-025 On a read with L>1, the accepting edge SHALL output word 0, set addr_q+1 and cnt=L-1, and move to BURST.
REQ-026 On each BURST edge the FSM SHALL output mem[addr_q] with dvalid=1, increment addr_q, and decrement cnt; it SHALL return to IDLE on the edge where cnt reaches 0.
REQ-027 A burst of L words SHALL produce exactly L consecutive dvalid cycles and SHALL hold busy high for L-1 cycles.
REQ-028 Address increment SHALL wrap modulo 2**AW, from 2**AW-1 to 0.
REQ-029 okay=1 while busy=1 SHALL drop the command (no memory write, no register change) and pulse err=1 for one cycle.
REQ-030 dataout SHALL hold its last value while dvalid=0.
REQ-031 A write and a read of the same address SHALL never occur on the same edge; a read after a write SHALL return the new data.

Reset
REQ-032 rst=1 SHALL immediately clear to 0: state (IDLE), addr_q, cnt, blen register, dataout, dvalid, busy, err, and all memory words.
REQ-033 Reset asserted mid-burst SHALL abort the burst with no further dvalid pulses; the first command after deassertion SHALL be accepted normally.

Verification (DW=8, AW=2)
REQ-034 LDAR address=2, then write 0xA5 with inc=0, then read -> dataout=0xA5, dvalid=1 for one cycle, addr_q=2.
REQ-035 LDAR address=0, then writes 0x11, 0x22, 0x33, 0x44 with inc=1, then LDAR address=3 blen=4, then read -> dvalid high 4 consecutive cycles with dataout 0x44, 0x11, 0x22, 0x33; busy high 3 cycles; addr_q=3 at end.
REQ-036 During the burst of REQ-035, pulse okay with rw=0 and datain=0xFF -> err=1 for one cycle, memory unchanged, burst data unaffected.
REQ-037 LDAR blen=0 then read -> single dvalid pulse, busy never asserted; LDAR blen=7 then read -> 4 words, then return to IDLE.
REQ-038 Assert rst on the second burst cycle -> dvalid, busy, dataout, addr_q=0 immediately; all memory reads return 0x00 afterwards.
